// File: rtl/multicycle_control.sv
// Multicycle RISC-V subset controller: FSM sequencing fetch, decode, memory,
// ALU, branch, jump and LUI steps, plus immediate-format and ALU-op decode.
module multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] rd_data,
   input  logic        mem_ready,
   input  logic        zero,
   output logic        mem_req,
   output logic [31:0] instr,
   output logic [2:0]  imm_src,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        mem_write,
   output logic        adr_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [2:0]  alu_ctrl,
   output logic        illegal,
   output logic [3:0]  state
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXEC_R   = 4'd6;
   localparam logic [3:0] S_EXEC_I   = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BEQ      = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_LUI      = 4'd11;
   localparam logic [3:0] S_TRAP     = 4'd12;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Operand selects: A = PC / old PC / register, B = register / immediate / 4
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_IMM = 2'b10;

   logic [3:0] state_q;
   logic [3:0] state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign state  = state_q;

   // State register and sticky illegal flag, raised on entry to TRAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         illegal <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_TRAP) illegal <= 1'b1;
      end
   end

   // Instruction register, loaded on the fetch handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        instr <= 32'd0;
      else if (ir_write) instr <= rd_data;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_BEQ:            state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUI;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ, S_JAL, S_LUI: state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_FETCH;
      endcase
   end

   // Control outputs per state; reset forces every enable low immediately
   always_comb begin
      mem_req    = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_REG;
      result_src = RES_ALU;
      alu_ctrl   = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_FOUR;
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            adr_src   = 1'b1;
            mem_write = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            result_src = RES_MEM;
         end
         S_EXEC_R, S_EXEC_I: begin
            alu_src_a = SRCA_REG;
            alu_src_b = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
            case (funct3)
               3'b000:  alu_ctrl = (state_q == S_EXEC_R && instr[30]) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_ctrl = ALU_SLT;
               3'b110:  alu_ctrl = ALU_OR;
               3'b111:  alu_ctrl = ALU_AND;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            result_src = RES_ALU;
         end
         S_BEQ: begin
            alu_src_a = SRCA_REG;
            alu_src_b = SRCB_REG;
            alu_ctrl  = ALU_SUB;
            pc_write  = zero;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            pc_write   = 1'b1;
            reg_write  = 1'b1;
            result_src = RES_ALU;
         end
         S_LUI: begin
            reg_write  = 1'b1;
            result_src = RES_IMM;
         end
         default: ;
      endcase
      if (!rst_n) begin
         mem_req   = 1'b0;
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
      end
   end

   // Immediate format from the latched opcode
   always_comb begin
      imm_src = 3'b000;
      case (opcode)
         OP_STORE: imm_src = 3'b010;
         OP_BEQ:   imm_src = 3'b011;
         OP_JAL:   imm_src = 3'b100;
         OP_LUI:   imm_src = 3'b001;
         default:  imm_src = 3'b000;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction scenarios plus random
// instruction streams, checked against a path-based reference model.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] rd_data;
   logic        mem_ready;
   logic        zero;
   logic        mem_req;
   logic [31:0] instr;
   logic [2:0]  imm_src;
   logic        pc_write, ir_write, reg_write, mem_write, adr_src;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [2:0]  alu_ctrl;
   logic        illegal;
   logic [3:0]  state;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .rd_data(rd_data), .mem_ready(mem_ready), .zero(zero),
      .mem_req(mem_req), .instr(instr), .imm_src(imm_src), .pc_write(pc_write),
      .ir_write(ir_write), .reg_write(reg_write), .mem_write(mem_write), .adr_src(adr_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .alu_ctrl(alu_ctrl), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: current step, remaining steps of the instruction, latched word
   int          m_state;
   int          path[$];
   logic [31:0] m_instr;
   logic        m_illegal;

   int   seen[$];
   int   rw_cnt, mw_cnt, ill_cnt;
   logic pcw9;
   logic [2:0] alu6;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] exp_alu(input int st, input logic [31:0] i);
      if (st == 9) return 3'b001;
      if (st == 6 || st == 7) begin
         case (i[14:12])
            3'b000:  return (st == 6 && i[30]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
         endcase
      end
      return 3'b000;
   endfunction

   function automatic logic [2:0] exp_imm(input logic [31:0] i);
      case (i[6:0])
         7'b0100011: return 3'b010;
         7'b1100011: return 3'b011;
         7'b1101111: return 3'b100;
         7'b0110111: return 3'b001;
         default:    return 3'b000;
      endcase
   endfunction

   // Steps an instruction visits after its fetch, by opcode class
   task automatic build_path(input logic [31:0] i);
      case (i[6:0])
         7'b0000011: path = {1, 2, 3, 4};
         7'b0100011: path = {1, 2, 5};
         7'b0110011: path = {1, 6, 8};
         7'b0010011: path = {1, 7, 8};
         7'b1100011: path = {1, 9};
         7'b1101111: path = {1, 10};
         7'b0110111: path = {1, 11};
         default:    path = {1, 12};
      endcase
   endtask

   task automatic model_step(input logic mr, input logic [31:0] rd);
      if (m_state == 0) begin
         if (mr) begin
            m_instr = rd;
            build_path(rd);
            m_state = path.pop_front();
         end
      end else if (m_state == 12) begin
         m_state = 12;
      end else if ((m_state == 3 || m_state == 5) && !mr) begin
         m_state = m_state;
      end else begin
         m_state = (path.size() > 0) ? path.pop_front() : 0;
      end
      if (m_state == 12) m_illegal = 1'b1;
   endtask

   // One clock: drive inputs after negedge, check outputs, then advance model
   task automatic cycle(input logic mr, input logic z, input logic [31:0] rd);
      int st;
      @(negedge clk);
      mem_ready = mr; zero = z; rd_data = rd;
      #1;
      st = m_state;
      chk("state",     32'(state),     32'(st));
      chk("mem_req",   32'(mem_req),   32'(st == 0 || st == 3 || st == 5));
      chk("ir_write",  32'(ir_write),  32'(st == 0 && mr));
      chk("pc_write",  32'(pc_write),  32'((st == 0 && mr) || (st == 9 && z) || st == 10));
      chk("reg_write", 32'(reg_write), 32'(st == 4 || st == 8 || st == 10 || st == 11));
      chk("mem_write", 32'(mem_write), 32'(st == 5));
      chk("alu_ctrl",  32'(alu_ctrl),  32'(exp_alu(st, m_instr)));
      chk("imm_src",   32'(imm_src),   32'(exp_imm(m_instr)));
      chk("illegal",   32'(illegal),   32'(m_illegal));
      chk("instr",     instr,          m_instr);
      if (st == 0 || st == 3 || st == 5) chk("adr_src", 32'(adr_src), 32'(st != 0));
      if (st == 4)  chk("result_src", 32'(result_src), 32'd1);
      if (st == 8)  chk("result_src", 32'(result_src), 32'd0);
      if (st == 11) chk("result_src", 32'(result_src), 32'd2);
      seen.push_back(int'(state));
      if (reg_write) rw_cnt++;
      if (mem_write) mw_cnt++;
      if (illegal)   ill_cnt++;
      if (state == 4'd9) pcw9 = pc_write;
      if (state == 4'd6) alu6 = alu_ctrl;
      @(posedge clk);
      model_step(mr, rd);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"},   32'(state),     32'd0);
      chk({tag, "_instr"},   instr,          32'd0);
      chk({tag, "_illegal"}, 32'(illegal),   32'd0);
      chk({tag, "_enables"}, 32'({mem_req, pc_write, ir_write, reg_write, mem_write}), 32'd0);
   endtask

   // Reset asserted mid-cycle; values must change without waiting for a clock edge
   task automatic async_reset(input string tag);
      @(negedge clk);
      mem_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_vals(tag);
      m_state = 0; path.delete(); m_instr = 32'd0; m_illegal = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one instruction from fetch back to FETCH (or into TRAP)
   task automatic exec_instr(input logic [31:0] ins, input int fstall, input int stall,
                             input logic z, input logic noisy);
      int budget;
      seen.delete(); rw_cnt = 0; mw_cnt = 0;
      repeat (fstall) cycle(1'b0, z, $urandom);
      cycle(1'b1, z, ins);
      budget = 0;
      while (m_state != 0 && m_state != 12 && budget < 40) begin
         if (m_state == 3 || m_state == 5) begin
            if (stall > 0) begin
               cycle(1'b0, z, $urandom);
               stall--;
            end else begin
               cycle(1'b1, z, $urandom);
            end
         end else begin
            cycle(noisy ? 1'($urandom_range(0, 1)) : 1'b1, z, $urandom);
         end
         budget++;
      end
      chk("budget", 32'(budget < 40), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   logic [6:0] ops [7];

   initial begin
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
              7'b1100011, 7'b1101111, 7'b0110111};
      m_state = 0; m_instr = 32'd0; m_illegal = 1'b0;
      rw_cnt = 0; mw_cnt = 0; ill_cnt = 0; pcw9 = 1'b0; alu6 = 3'b000;
      rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; rd_data = 32'd0;
      #2;
      chk_reset_vals("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // lw, always ready: 0,1,2,3,4 then back to FETCH
      exec_instr(32'h00402083, 0, 0, 1'b0, 1'b0);
      chk("lw_len", 32'(seen.size()), 32'd5);
      for (int i = 0; i < 5 && i < seen.size(); i++) chk("lw_seq", 32'(seen[i]), 32'(i));
      chk("lw_regw_cnt", 32'(rw_cnt), 32'd1);

      // sw with three wait cycles in MEMWRITE
      exec_instr(32'h00112223, 0, 3, 1'b0, 1'b0);
      chk("sw_memw_cnt", 32'(mw_cnt), 32'd4);
      chk("sw_regw_cnt", 32'(rw_cnt), 32'd0);

      // beq taken then not taken
      exec_instr(32'h00208463, 0, 0, 1'b1, 1'b0);
      chk("beq_taken", 32'(pcw9), 32'd1);
      exec_instr(32'h00208463, 0, 0, 1'b0, 1'b0);
      chk("beq_not_taken", 32'(pcw9), 32'd0);

      // R-type sub and add
      exec_instr(32'h40208033, 1, 0, 1'b0, 1'b0);
      chk("sub_alu", 32'(alu6), 32'd1);
      exec_instr(32'h00208033, 0, 0, 1'b0, 1'b0);
      chk("add_alu", 32'(alu6), 32'd0);

      // Random legal instructions, random waits and stray mem_ready pulses
      for (int n = 0; n < 60; n++) begin
         logic [31:0] r;
         r = $urandom;
         exec_instr({r[31:7], ops[$urandom_range(0, 6)]}, $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1);
      end

      // Reset while MEMREAD is waiting on memory
      rw_cnt = 0;
      cycle(1'b1, 1'b0, 32'h00402083);
      cycle(1'b1, 1'b0, $urandom);
      cycle(1'b1, 1'b0, $urandom);
      cycle(1'b0, 1'b0, $urandom);
      chk("memread_reached", 32'(seen[seen.size() - 1]), 32'd3);
      async_reset("rst_memread");
      cycle(1'b0, 1'b0, $urandom);
      chk("rst_memread_regw", 32'(rw_cnt), 32'd0);

      // Unsupported opcode: TRAP holds with illegal set until reset
      exec_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
      ill_cnt = 0;
      repeat (10) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      chk("trap_illegal_cycles", 32'(ill_cnt), 32'd10);
      async_reset("rst_trap");

      // Normal operation resumes after leaving TRAP
      exec_instr(32'h00402083, 0, 1, 1'b0, 1'b0);
      chk("post_trap_regw", 32'(rw_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
